// File: rtl/fetch_wf_rr_scheduler.sv
// Round-robin fetch scheduler over NUM_WF wavefront slots. It holds each grant until
// fetch acknowledges it, and marks granted slots busy until fetch releases them.
module fetch_wf_rr_scheduler #(
    parameter int unsigned NUM_WF  = 40,
    parameter int unsigned WF_ID_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_WF-1:0]  wf_ready_i,
    input  logic               sched_halt_i,
    input  logic               grant_ack_i,
    input  logic               release_valid_i,
    input  logic [WF_ID_W-1:0] release_wf_id_i,
    output logic               grant_valid_o,
    output logic [WF_ID_W-1:0] grant_wf_id_o,
    output logic [NUM_WF-1:0]  grant_onehot_o,
    output logic [NUM_WF-1:0]  busy_mask_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WF_ID_W-1:0]   ptr_q, ptr_d;
    logic [NUM_WF-1:0]    busy_q, busy_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [WF_ID_W-1:0]   grant_wf_id_q, grant_wf_id_d;
    logic [NUM_WF-1:0]    grant_onehot_q, grant_onehot_d;

    logic [NUM_WF-1:0]    elig;
    logic [WF_ID_W-1:0]   winner;
    logic                 found;
    logic                 issue;

    // Slot index ptr+k, wrapped into 0..NUM_WF-1
    function automatic int unsigned wrap_idx(input logic [WF_ID_W-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_WF) s = s - NUM_WF;
        return s;
    endfunction

    // Rotating-priority scan starting at ptr_q
    always_comb begin
        elig   = wf_ready_i & ~busy_q;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_WF; k++) begin
            if (!found && elig[wrap_idx(ptr_q, k)]) begin
                found  = 1'b1;
                winner = WF_ID_W'(wrap_idx(ptr_q, k));
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        busy_d         = busy_q;
        grant_valid_d  = grant_valid_q;
        grant_wf_id_d  = grant_wf_id_q;
        grant_onehot_d = grant_onehot_q;
        issue          = 1'b0;

        case (state_q)
            IDLE:    issue = !sched_halt_i && found;
            GRANT:   issue = !sched_halt_i && found && grant_ack_i;
            default: issue = 1'b0;
        endcase

        if (release_valid_i && (32'(release_wf_id_i) < NUM_WF)) begin
            busy_d[release_wf_id_i] = 1'b0;
        end

        if (issue) begin
            state_d        = GRANT;
            grant_valid_d  = 1'b1;
            grant_wf_id_d  = winner;
            grant_onehot_d = NUM_WF'(1) << winner;
            busy_d[winner] = 1'b1;
            ptr_d          = (32'(winner) == NUM_WF - 1) ? '0 : winner + WF_ID_W'(1);
        end else if (state_q == GRANT && grant_ack_i) begin
            state_d        = IDLE;
            grant_valid_d  = 1'b0;
            grant_onehot_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            busy_q         <= '0;
            grant_valid_q  <= 1'b0;
            grant_wf_id_q  <= '0;
            grant_onehot_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            busy_q         <= busy_d;
            grant_valid_q  <= grant_valid_d;
            grant_wf_id_q  <= grant_wf_id_d;
            grant_onehot_q <= grant_onehot_d;
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_wf_id_o  = grant_wf_id_q;
    assign grant_onehot_o = grant_onehot_q;
    assign busy_mask_o    = busy_q;

endmodule

// File: tb/tb_fetch_wf_rr_scheduler.sv
// Bench for fetch_wf_rr_scheduler: directed scenarios plus random traffic, all checked
// against a slot-level behavioural model of the scheduler.
module tb_fetch_wf_rr_scheduler;

    localparam int unsigned NUM_WF  = 40;
    localparam int unsigned WF_ID_W = 6;

    logic               clk;
    logic               rst;
    logic [NUM_WF-1:0]  wf_ready;
    logic               sched_halt;
    logic               grant_ack;
    logic               release_valid;
    logic [WF_ID_W-1:0] release_wf_id;
    logic               grant_valid;
    logic [WF_ID_W-1:0] grant_wf_id;
    logic [NUM_WF-1:0]  grant_onehot;
    logic [NUM_WF-1:0]  busy_mask;

    int n_vec;
    int n_err;

    // Model state: what the scheduler should be showing
    bit              m_valid;
    int              m_id;
    int              m_ptr;
    bit [NUM_WF-1:0] m_busy;

    fetch_wf_rr_scheduler #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .wf_ready_i      (wf_ready),
        .sched_halt_i    (sched_halt),
        .grant_ack_i     (grant_ack),
        .release_valid_i (release_valid),
        .release_wf_id_i (release_wf_id),
        .grant_valid_o   (grant_valid),
        .grant_wf_id_o   (grant_wf_id),
        .grant_onehot_o  (grant_onehot),
        .busy_mask_o     (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First ready-and-free slot in circular order from the model pointer, -1 if none
    function automatic int pick(input bit [NUM_WF-1:0] ready, input bit [NUM_WF-1:0] busy, input int ptr);
        for (int k = 0; k < NUM_WF; k++) begin
            int s;
            s = (ptr + k) % NUM_WF;
            if (ready[s] && !busy[s]) return s;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        bit [NUM_WF-1:0] exp_oh;
        exp_oh = m_valid ? (NUM_WF'(1) << m_id) : '0;
        check({tag, "_valid"},  64'(grant_valid),  64'(m_valid));
        check({tag, "_id"},     64'(grant_wf_id),  64'(m_id));
        check({tag, "_onehot"}, 64'(grant_onehot), 64'(exp_oh));
        check({tag, "_busy"},   64'(busy_mask),    64'(m_busy));
    endtask

    // One clock: predict from current inputs, advance, compare
    task automatic cycle(input string tag);
        int w;
        bit iss;
        bit [NUM_WF-1:0] nb;
        w   = pick(wf_ready, m_busy, m_ptr);
        iss = !sched_halt && (w >= 0) && (!m_valid || grant_ack);
        nb  = m_busy;
        if (release_valid && int'(release_wf_id) < NUM_WF) nb[release_wf_id] = 1'b0;
        if (iss) nb[w] = 1'b1;
        @(posedge clk);
        #1;
        if (iss) begin
            m_valid = 1'b1;
            m_id    = w;
            m_ptr   = (w + 1) % NUM_WF;
        end else if (m_valid && grant_ack) begin
            m_valid = 1'b0;
        end
        m_busy = nb;
        check_outputs(tag);
    endtask

    task automatic clear_inputs();
        wf_ready      = '0;
        sched_halt    = 1'b0;
        grant_ack     = 1'b0;
        release_valid = 1'b0;
        release_wf_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        m_valid = 1'b0; m_id = 0; m_ptr = 0; m_busy = '0;
        check_outputs("reset");
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        do_reset();

        // Two requesters, ack tied high
        wf_ready = (NUM_WF'(1) << 3) | (NUM_WF'(1) << 7);
        grant_ack = 1'b1;
        cycle("t1a"); check("t1_first", 64'(grant_wf_id), 64'd3);
        cycle("t1b"); check("t1_second", 64'(grant_wf_id), 64'd7);
        check("t1_busy", 64'(busy_mask), 64'h88);
        cycle("t1c"); check("t1_drop", 64'(grant_valid), 64'd0);

        // All 40 slots, one grant per cycle in order
        do_reset();
        wf_ready = '1;
        grant_ack = 1'b1;
        for (int i = 0; i < NUM_WF; i++) begin
            cycle("t2");
            check("t2_order", 64'(grant_wf_id), 64'(i));
        end
        cycle("t2end");
        check("t2_busy_all", 64'(busy_mask), 64'hFF_FFFF_FFFF);
        check("t2_idle", 64'(grant_valid), 64'd0);

        // Pointer at 39 then wrap to slot 2
        do_reset();
        wf_ready = NUM_WF'({NUM_WF{1'b1}} >> 1);
        grant_ack = 1'b1;
        for (int i = 0; i < NUM_WF; i++) cycle("t3fill");
        wf_ready = '0;
        for (int i = 0; i < NUM_WF - 1; i++) begin
            release_valid = 1'b1;
            release_wf_id = WF_ID_W'(i);
            cycle("t3rel");
        end
        release_valid = 1'b0;
        wf_ready = (NUM_WF'(1) << 39) | (NUM_WF'(1) << 2);
        cycle("t3a"); check("t3_39", 64'(grant_wf_id), 64'd39);
        cycle("t3b"); check("t3_wrap", 64'(grant_wf_id), 64'd2);

        // Held grant stays put while ready toggles
        do_reset();
        wf_ready = NUM_WF'(1) << 5;
        cycle("t4g");
        for (int i = 0; i < 10; i++) begin
            wf_ready = NUM_WF'({$urandom, $urandom});
            sched_halt = 1'($urandom);
            cycle("t4hold");
            check("t4_id", 64'(grant_wf_id), 64'd5);
            check("t4_oh", 64'(grant_onehot), 64'h20);
        end
        sched_halt = 1'b0;
        wf_ready = NUM_WF'(1) << 9;
        grant_ack = 1'b1;
        cycle("t4ack"); check("t4_next", 64'(grant_wf_id), 64'd9);

        // Halt blocks issue
        do_reset();
        sched_halt = 1'b1;
        wf_ready = NUM_WF'(1);
        repeat (3) cycle("t5halt");
        check("t5_nogrant", 64'(grant_valid), 64'd0);
        sched_halt = 1'b0;
        cycle("t5go"); check("t5_grant0", 64'(grant_valid), 64'd1);

        // Release of slot 4 is visible one cycle later; out-of-range release ignored
        do_reset();
        wf_ready = NUM_WF'(1) << 4;
        grant_ack = 1'b1;
        cycle("t6g");
        cycle("t6idle");
        release_valid = 1'b1; release_wf_id = WF_ID_W'(4);
        cycle("t6rel"); check("t6_notyet", 64'(grant_valid), 64'd0);
        release_valid = 1'b0;
        cycle("t6regrant"); check("t6_slot4", 64'(grant_wf_id), 64'd4);
        release_valid = 1'b1; release_wf_id = WF_ID_W'(45);
        grant_ack = 1'b0;
        cycle("t6oob"); check("t6_busy", 64'(busy_mask), 64'h10);
        release_valid = 1'b0;
        #2;
        do_reset();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            wf_ready      = NUM_WF'({$urandom, $urandom}) & NUM_WF'({$urandom, $urandom});
            sched_halt    = ($urandom_range(7, 0) == 0);
            grant_ack     = 1'($urandom);
            release_valid = 1'($urandom);
            release_wf_id = WF_ID_W'($urandom_range(47, 0));
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_wf_rr_scheduler.md
Name: fetch_wf_rr_scheduler

Overview:
Round-robin scheduler that chooses which of the 40 wavefront slots the fetch stage serves next. It takes per-wavefront ready bits and gives each chosen slot a one-hot grant plus a 6-bit slot ID. It holds each grant until fetch acknowledges it. It masks a granted slot as busy until fetch releases it, so the same slot cannot be granted twice while in flight.

Parameters:
NUM_WF, 40, number of wavefront slots arbitrated
WF_ID_W, 6, width of a slot ID; must satisfy 2^WF_ID_W >= NUM_WF

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
wf_ready  input  NUM_WF  bit i = slot i requests fetch
sched_halt  input  1  while 1, no new grant is issued; a held grant stays until acked
grant_ack  input  1  fetch accepts the current grant; only meaningful while grant_valid=1
release_valid  input  1  fetch has finished with slot release_wf_id
release_wf_id  input  WF_ID_W  slot to clear from the busy mask
grant_valid  output  1  grant outputs are valid
grant_wf_id  output  WF_ID_W  binary ID of the granted slot
grant_onehot  output  NUM_WF  one-hot form of grant_wf_id; all-zero when grant_valid=0
busy_mask  output  NUM_WF  bit i = slot i granted and not yet released

Behaviour:
- Reset values, applied asynchronously:
  - grant_valid=0, grant_wf_id=0, grant_onehot=0, busy_mask=0.
  - Round-robin pointer ptr=0; FSM=IDLE.
- Eligibility: elig = wf_ready & ~busy_mask, using the registered busy_mask.
  - A release takes effect for eligibility on the cycle after release_valid.
- Winner: the first set bit of elig scanning ptr, ptr+1, ..., NUM_WF-1, 0, ..., ptr-1. Index wraps from NUM_WF-1 to 0.
- Issue: allowed when sched_halt=0, elig != 0, and either FSM=IDLE or (FSM=GRANT and grant_ack=1).
- On issue, at the next edge:
  - grant_valid<=1; grant_wf_id<=winner; grant_onehot<=1<<winner.
  - busy_mask[winner]<=1.
  - ptr<=winner+1, wrapping NUM_WF-1 to 0.
- FSM states and transitions:
  - IDLE -> GRANT on issue; otherwise stay in IDLE.
  - GRANT with grant_ack=0: hold grant_valid, grant_wf_id and grant_onehot stable, independent of wf_ready changes and sched_halt.
  - GRANT with grant_ack=1 and issue: stay in GRANT and load the new winner. Back-to-back grants run with zero bubble.
  - GRANT with grant_ack=1 and no issue (halted or elig=0): go to IDLE; grant_valid<=0, grant_onehot<=0; grant_wf_id keeps its last value.
- Latency: a wf_ready rise at edge N with the scheduler IDLE and unhalted gives grant_valid=1 after edge N+1.
- Ack while in the same cycle: during an ack cycle, the slot being acked is already busy and so is excluded from the winner scan.
- Busy bit update rules:
  - release_valid clears busy_mask[release_wf_id].
  - Release of a slot that is not busy has no effect.
  - release_wf_id >= NUM_WF is ignored.
  - If a set (issue) and a clear (release) target the same bit in one cycle, the set wins.
  - Releasing a slot whose grant is still held (unacked) clears its busy bit; the held grant is unaffected.
- grant_ack while grant_valid=0 is ignored.
- grant_onehot is always exactly the decode of grant_wf_id when grant_valid=1.
- Reset asserted mid-grant: all state returns to reset values immediately; no ack is required.

Test Plan:
- Reset, then wf_ready=bits {3,7}, grant_ack tied 1 -> grants 3, then 7, on consecutive cycles; busy_mask=0x88; grant_valid falls after the grant of 7 is acked.
- wf_ready=all 40 bits, ack every cycle, no releases -> grants 0,1,...,39 in order, one per cycle; busy_mask=0xFF_FFFF_FFFF; grant_valid then 0.
- With ptr=39 (slots 0..38 granted then released), wf_ready={39,2} -> grant 39, then wrap to 2.
- Grant of slot 5 held with ack=0 for 10 cycles while wf_ready toggles -> grant_wf_id=5 and grant_onehot=0x20 stable throughout; ack -> next winner follows.
- sched_halt=1 with wf_ready=0x1 -> no grant; deassert halt -> grant 0 one cycle later.
- Release slot 4 in the same cycle it would otherwise win -> no grant of 4 that cycle; granted on the following cycle. Also: release_wf_id=45 -> busy_mask unchanged. Also: rst pulse mid-hold -> all outputs 0 asynchronously.
